// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared states, error codes and defaults for the UART command controller
package uart_cmd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK, S_COMMIT} uart_cmd_state_t;
  typedef enum logic [1:0] {ERR_LEN = 2'd0, ERR_CHK = 2'd1, ERR_TIMEOUT = 2'd2, ERR_OVERRUN = 2'd3} uart_cmd_err_t;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
endpackage

// File: rtl/uart_cmd_timer.sv
// uart_cmd_timer: inter-byte timeout counter, pulses expire once it reaches TIMEOUT_CYCLES-1
module uart_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 174
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt <= '0;
    else cnt <= (clr || !en) ? '0 : cnt + CW'(1);
  assign expire = en && cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames uart_rx bytes (SYNC ADDR LEN DATA.. [CHK]) into buffered register-write bursts
// Checksum byte and CHK error exist only when UART_CMD_CHK_EN is defined.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         CLK_FREQ     = 50000000,
  parameter int         BAUD_RATE    = 115200,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         ADDR_W       = 8,
  parameter int         MAX_LEN      = 8,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_data_valid,
  input  logic [7:0]        i_data,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic              o_busy
);
  // Round to nearest: an exact integer ratio must not be bumped up by the +0.5.
  localparam int TIMEOUT_CYCLES = $rtoi(real'(TIMEOUT_BITS) * real'(CLK_FREQ) / real'(BAUD_RATE) + 0.5);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
`ifdef UART_CMD_CHK_EN
  localparam uart_cmd_state_t S_AFTER_DATA = S_CHK;
`else
  localparam uart_cmd_state_t S_AFTER_DATA = S_COMMIT;
`endif
  uart_cmd_state_t state, state_n;
  uart_cmd_err_t code_n;
  logic [ADDR_W-1:0] base;
  logic [LW-1:0] len, idx;
  logic [7:0] mem [2**IW];
  logic expire, err_n, done_n, accept, last_data, last_wr, bad_len;
  assign accept    = state == S_COMMIT && i_wr_ready;
  assign last_wr   = accept && idx + LW'(1) == len;
  assign last_data = state == S_DATA && i_data_valid && idx + LW'(1) == len;
  assign bad_len   = i_data == 8'd0 || int'(i_data) > MAX_LEN;
  uart_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr    (i_data_valid || state_n != state),
    .en     (state inside {S_ADDR, S_LEN, S_DATA, S_CHK}),
    .expire (expire)
  );
`ifdef UART_CMD_CHK_EN
  logic [7:0] chk;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) chk <= '0;
    else if (i_data_valid) chk <= state == S_ADDR ? i_data : chk ^ i_data;
`endif
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    code_n  = ERR_LEN;
    done_n  = 1'b0;
    case (state)
      S_IDLE: state_n = i_data_valid && i_data == SYNC_BYTE ? S_ADDR : S_IDLE;
      S_ADDR: state_n = i_data_valid ? S_LEN : S_ADDR;
      S_LEN: begin
        state_n = i_data_valid ? (bad_len ? S_IDLE : S_DATA) : S_LEN;
        err_n   = i_data_valid && bad_len;
      end
      S_DATA: state_n = last_data ? S_AFTER_DATA : S_DATA;
      S_CHK: begin
`ifdef UART_CMD_CHK_EN
        state_n = i_data_valid ? (i_data == chk ? S_COMMIT : S_IDLE) : S_CHK;
        err_n   = i_data_valid && i_data != chk;
        code_n  = ERR_CHK;
`else
        state_n = S_IDLE;
`endif
      end
      S_COMMIT: begin
        state_n = last_wr ? S_IDLE : S_COMMIT;
        done_n  = last_wr;
        err_n   = i_data_valid;
        code_n  = ERR_OVERRUN;
      end
      default: state_n = S_IDLE;
    endcase
    // A byte arriving on the expiry cycle takes precedence over the timeout.
    if (expire && !i_data_valid) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
      code_n  = ERR_TIMEOUT;
    end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      base       <= '0;
      len        <= '0;
      idx        <= '0;
      o_err      <= 1'b0;
      o_err_code <= '0;
      o_done     <= 1'b0;
    end else begin
      o_err      <= err_n;
      o_err_code <= err_n ? code_n : '0;
      o_done     <= done_n;
      if (i_data_valid && state == S_ADDR) base <= ADDR_W'(i_data);
      if (i_data_valid && state == S_LEN) begin
        len <= LW'(i_data);
        idx <= '0;
      end
      if (i_data_valid && state == S_DATA) idx <= last_data ? '0 : idx + LW'(1);
      if (accept) idx <= idx + LW'(1);
    end
  always_ff @(posedge clk)
    if (i_data_valid && state == S_DATA) mem[idx[IW-1:0]] <= i_data;
  assign o_wr_valid = state == S_COMMIT;
  assign o_wr_addr  = o_wr_valid ? base + ADDR_W'(idx) : '0;
  assign o_wr_data  = o_wr_valid ? mem[idx[IW-1:0]] : '0;
  assign o_busy     = state != S_IDLE;
endmodule
